// File: rtl/proc_pkg.sv
// Shared definitions for the instruction issue stage: field layout, widths and FSM states.
package proc_pkg;

  localparam int unsigned INSTR_W     = 32;
  localparam int unsigned OPC_W       = 5;
  localparam int unsigned REG_W       = 5;
  localparam int unsigned IMM_W       = 12;
  localparam int unsigned DEF_MC_BASE = 24;

  localparam int unsigned OPC_LSB = 27;
  localparam int unsigned RD_LSB  = 22;
  localparam int unsigned RS1_LSB = 17;
  localparam int unsigned RS2_LSB = 12;
  localparam int unsigned IMM_LSB = 0;

  // Field order matches the bit positions above, MSB first.
  typedef struct packed {
    logic [OPC_W-1:0] opc;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [IMM_W-1:0] imm;
  } instr_t;

  typedef enum logic [0:0] {
    StRun,
    StWait
  } issue_state_e;

  function automatic logic is_multi_cycle(logic [OPC_W-1:0] opc, int unsigned mc_base);
    return 32'(opc) >= mc_base;
  endfunction

endpackage

// File: rtl/opcode_issue_if.sv
// Upstream instruction handshake plus decoder-facing issue outputs of opcode_issue.
interface opcode_issue_if
  import proc_pkg::*;
#(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic               hold;
  logic               flush;
  logic [OPC_W-1:0]   opcode;
  logic               enable;
  logic [REG_W-1:0]   rd;
  logic [REG_W-1:0]   rs1;
  logic [REG_W-1:0]   rs2;
  logic [IMM_W-1:0]   imm;
  logic               busy;
  logic [CntW-1:0]    count;

  modport master (
    output in_valid, in_instr, hold, flush,
    input  in_ready, opcode, enable, rd, rs1, rs2, imm, busy, count
  );

  modport slave (
    input  in_valid, in_instr, hold, flush,
    output in_ready, opcode, enable, rd, rs1, rs2, imm, busy, count
  );

endinterface

// File: rtl/instr_fifo.sv
// Instruction word FIFO; flush clears occupancy and pointers and overrides push/pop.
module instr_fifo
  import proc_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic [INSTR_W-1:0]           wdata_i,
  output logic [INSTR_W-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [INSTR_W-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               push_ok, pop_ok;

  // Guard locally so a misbehaving caller can never over- or under-run.
  assign push_ok = push_i && !flush_i && (count_q != CntW'(DEPTH));
  assign pop_ok  = pop_i && !flush_i && (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/opcode_issue.sv
// Issue stage ahead of the ALU decoder: buffers instructions and pulses enable once per issue,
// blocking further issue while a multi-cycle opcode occupies the ALU.
module opcode_issue
  import proc_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MC_BASE   = DEF_MC_BASE,
  parameter int unsigned MC_CYCLES = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  opcode_issue_if.slave bus
);

  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned WaitW = $clog2(MC_CYCLES + 1);

  logic [CntW-1:0]    count;
  logic [INSTR_W-1:0] head;
  logic               in_ready;
  logic               fifo_push;
  logic               fifo_pop;
  instr_t             head_fields;

  issue_state_e       state_q, state_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic               enable_q, enable_d;
  logic               busy_q, busy_d;
  instr_t             fields_q, fields_d;

  assign in_ready    = (count != CntW'(DEPTH)) && !bus.flush;
  assign fifo_push   = bus.in_valid && in_ready;
  assign head_fields = head;

  instr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (bus.flush),
    .wdata_i (bus.in_instr),
    .rdata_o (head),
    .count_o (count)
  );

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    fields_d = fields_q;
    enable_d = 1'b0;
    fifo_pop = 1'b0;
    unique case (state_q)
      StRun: begin
        if ((count != '0) && !bus.hold && !bus.flush) begin
          fifo_pop = 1'b1;
          enable_d = 1'b1;
          fields_d = head_fields;
          if (is_multi_cycle(head_fields.opc, MC_BASE)) begin
            state_d = StWait;
            wait_d  = WaitW'(MC_CYCLES - 1);
          end
        end
      end
      StWait: begin
        // Countdown runs regardless of hold; issue resumes the edge after reaching RUN.
        if (wait_q == WaitW'(1)) begin
          state_d = StRun;
          wait_d  = '0;
        end else begin
          wait_d = wait_q - WaitW'(1);
        end
      end
    endcase
    if (bus.flush) begin
      state_d  = StRun;
      wait_d   = '0;
      enable_d = 1'b0;
      fifo_pop = 1'b0;
    end
    busy_d = (state_d == StWait);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StRun;
      wait_q   <= '0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      fields_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
      fields_q <= fields_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.count    = count;
  assign bus.enable   = enable_q;
  assign bus.busy     = busy_q;
  assign bus.opcode   = fields_q.opc;
  assign bus.rd       = fields_q.rd;
  assign bus.rs1      = fields_q.rs1;
  assign bus.rs2      = fields_q.rs2;
  assign bus.imm      = fields_q.imm;

endmodule

// File: tb/tb_opcode_issue.sv
// Directed and random stimulus for opcode_issue, checked cycle by cycle against a queue-based model.
module tb_opcode_issue;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned MC_BASE   = 24;
  localparam int unsigned MC_CYCLES = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  opcode_issue_if #(.DEPTH(DEPTH)) bus ();

  opcode_issue #(
    .DEPTH     (DEPTH),
    .MC_BASE   (MC_BASE),
    .MC_CYCLES (MC_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: pending instructions, cycles the ALU stays blocked, last issued word.
  logic [31:0] mq[$];
  int          blocked;
  logic        m_en;
  logic        m_busy;
  logic [31:0] m_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    blocked = 0;
    m_en    = 1'b0;
    m_busy  = 1'b0;
    m_last  = '0;
  endfunction

  function automatic void model_edge(logic v, logic [31:0] ins, logic h, logic f);
    logic ready;
    logic can_issue;
    ready = (mq.size() != DEPTH) && !f;
    if (f) begin
      mq.delete();
      blocked = 0;
      m_en    = 1'b0;
    end else begin
      can_issue = (blocked == 0) && (mq.size() != 0) && !h;
      if (blocked > 0) blocked--;
      m_en = can_issue;
      if (can_issue) begin
        m_last = mq.pop_front();
        if (m_last[31:27] >= MC_BASE) blocked = MC_CYCLES - 1;
      end
      if (v && ready) mq.push_back(ins);
    end
    m_busy = (blocked > 0);
  endfunction

  task automatic check_outputs();
    chk("enable", 32'(bus.enable), 32'(m_en));
    chk("busy",   32'(bus.busy),   32'(m_busy));
    chk("count",  32'(bus.count),  32'(mq.size()));
    chk("opcode", 32'(bus.opcode), 32'(m_last[31:27]));
    chk("rd",     32'(bus.rd),     32'(m_last[26:22]));
    chk("rs1",    32'(bus.rs1),    32'(m_last[21:17]));
    chk("rs2",    32'(bus.rs2),    32'(m_last[16:12]));
    chk("imm",    32'(bus.imm),    32'(m_last[11:0]));
  endtask

  // Called at a negedge: drive, check in_ready, take the edge, check registered outputs.
  task automatic step(input logic v, input logic [31:0] ins, input logic h, input logic f);
    logic exp_ready;
    bus.in_valid = v;
    bus.in_instr = ins;
    bus.hold     = h;
    bus.flush    = f;
    #1;
    exp_ready = (mq.size() != DEPTH) && !f;
    chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    @(posedge clk);
    model_edge(v, ins, h, f);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] mk(input logic [4:0] opc);
    logic [31:0] r;
    r = $urandom;
    r[31:27] = opc;
    return r;
  endfunction

  task automatic async_reset();
    bus.in_valid = 1'b0;
    bus.hold     = 1'b0;
    bus.flush    = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("in_ready_rst", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.hold     = 1'b0;
    bus.flush    = 1'b0;
    model_reset();
    @(negedge clk);
    check_outputs();
    chk("in_ready_rst", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;

    // Back-to-back single-cycle ops.
    step(1'b1, mk(5'd2), 1'b0, 1'b0);
    step(1'b1, mk(5'd5), 1'b0, 1'b0);
    step(1'b1, mk(5'd7), 1'b0, 1'b0);
    idle(4);

    // Multi-cycle op followed by a single-cycle op.
    step(1'b1, mk(5'd25), 1'b0, 1'b0);
    step(1'b1, mk(5'd3), 1'b0, 1'b0);
    idle(6);

    // Fill under hold, fifth push refused, drain, then wrap the pointers.
    for (int i = 0; i < 5; i++) step(1'b1, mk(5'(i + 1)), 1'b1, 1'b0);
    idle(6);
    for (int i = 0; i < 3; i++) step(1'b1, mk(5'(i + 10)), 1'b0, 1'b0);
    idle(4);

    // Full FIFO, push attempted while an issue pops.
    for (int i = 0; i < 4; i++) step(1'b1, mk(5'(i + 16)), 1'b1, 1'b0);
    step(1'b1, mk(5'd9), 1'b0, 1'b0);
    step(1'b1, mk(5'd10), 1'b1, 1'b0);
    idle(6);

    // Flush while in WAIT with two queued entries and in_valid high.
    step(1'b1, mk(5'd25), 1'b0, 1'b0);
    step(1'b1, mk(5'd1), 1'b0, 1'b0);
    step(1'b1, mk(5'd2), 1'b0, 1'b0);
    step(1'b1, mk(5'd4), 1'b0, 1'b1);
    idle(3);

    // Asynchronous reset with three entries queued and the ALU blocked.
    step(1'b1, mk(5'd26), 1'b1, 1'b0);
    step(1'b1, mk(5'd1), 1'b1, 1'b0);
    step(1'b1, mk(5'd2), 1'b0, 1'b0);
    step(1'b1, mk(5'd3), 1'b0, 1'b0);
    async_reset();
    idle(2);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] opc;
      opc = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
      step(($urandom_range(0, 3) != 0), mk(opc), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 24) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
